sd_read_arbiter: RTL and testbench

- Shares one sd_controller block-read port between two requesters: port 0 (instruction pseudocache) and port 1 (data pseudocache).
- Arbitrates round-robin and drives the controller's rd_en/addr level handshake.
- Captures the 4096-bit block, returns it to the winning requester with a one-cycle ack.
- Flags SD reads that never complete via a timeout counter.

---
 rtl/sd_read_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sd_read_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing one sd_controller block-read port between two requesters.
// Optional last-block hit shortcut enabled by defining SD_ARB_LAST_BLOCK_HIT_EN.
module sd_read_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16777216,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req0,
   input  logic [31:0]   addr0,
   output logic          ack0,
   input  logic          req1,
   input  logic [31:0]   addr1,
   output logic          ack1,
   output logic [4095:0] read_data,
   output logic          err,
   output logic          sd_rd_en,
   output logic [31:0]   sd_addr,
   input  logic [4095:0] sd_read_data,
   input  logic          sd_busy,
   output logic          grant
);

   typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StRespond} state_t;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic             grant_q, grant_d;
   logic             last_grant_q, last_grant_d;
   logic [31:0]      sd_addr_q, sd_addr_d;
   logic             sd_rd_en_q, sd_rd_en_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             err_q, err_d;
   logic             ack0_q, ack0_d, ack1_q, ack1_d;
   logic [4095:0]    read_data_q;
   logic             capture, timeout, pick, respond, resp_port;
   logic [31:0]      pick_addr;
`ifdef SD_ARB_LAST_BLOCK_HIT_EN
   logic [31:0]      tag_q, tag_d;
   logic             tag_valid_q, tag_valid_d;
   logic             hit;
`endif

   always_comb begin
      if (req0 && req1) pick = ~last_grant_q;
      else              pick = req1;
      pick_addr = pick ? addr1 : addr0;
      timeout   = (cnt_q >= CntLast);
      cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
`ifdef SD_ARB_LAST_BLOCK_HIT_EN
      hit         = tag_valid_q && (pick_addr == tag_q);
      tag_d       = tag_q;
      tag_valid_d = tag_valid_q;
`endif
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      sd_addr_d    = sd_addr_q;
      sd_rd_en_d   = sd_rd_en_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      capture      = 1'b0;
      respond      = 1'b0;
      resp_port    = grant_q;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               grant_d   = pick;
               sd_addr_d = pick_addr;
               cnt_d     = '0;
               resp_port = pick;
`ifdef SD_ARB_LAST_BLOCK_HIT_EN
               if (hit) begin
                  err_d   = 1'b0;
                  respond = 1'b1;
                  state_d = StRespond;
               end else begin
                  sd_rd_en_d = 1'b1;
                  state_d    = StIssue;
               end
`else
               sd_rd_en_d = 1'b1;
               state_d    = StIssue;
`endif
            end
         end
         StIssue: begin
            cnt_d = cnt_inc;
            // Busy in Issue is only an acknowledge, not completion, so timeout takes priority here.
            if (timeout) begin
               err_d      = 1'b1;
               sd_rd_en_d = 1'b0;
               respond    = 1'b1;
               state_d    = StRespond;
`ifdef SD_ARB_LAST_BLOCK_HIT_EN
               tag_valid_d = 1'b0;
`endif
            end else if (sd_busy) begin
               sd_rd_en_d = 1'b0;
               state_d    = StWaitDone;
            end
         end
         StWaitDone: begin
            cnt_d = cnt_inc;
            if (!sd_busy) begin
               capture = 1'b1;
               err_d   = 1'b0;
               respond = 1'b1;
               state_d = StRespond;
`ifdef SD_ARB_LAST_BLOCK_HIT_EN
               tag_d       = sd_addr_q;
               tag_valid_d = 1'b1;
`endif
            end else if (timeout) begin
               err_d      = 1'b1;
               sd_rd_en_d = 1'b0;
               respond    = 1'b1;
               state_d    = StRespond;
`ifdef SD_ARB_LAST_BLOCK_HIT_EN
               tag_valid_d = 1'b0;
`endif
            end
         end
         StRespond: begin
            last_grant_d = grant_q;
            state_d      = StIdle;
         end
      endcase

      // Ack is registered on entry to Respond so it is high exactly during the Respond cycle.
      ack0_d = respond && !resp_port;
      ack1_d = respond &&  resp_port;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         sd_addr_q    <= '0;
         sd_rd_en_q   <= 1'b0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         sd_addr_q    <= sd_addr_d;
         sd_rd_en_q   <= sd_rd_en_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset)        read_data_q <= '0;
      else if (capture) read_data_q <= sd_read_data;
   end

`ifdef SD_ARB_LAST_BLOCK_HIT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         tag_q       <= '0;
         tag_valid_q <= 1'b0;
      end else begin
         tag_q       <= tag_d;
         tag_valid_q <= tag_valid_d;
      end
   end
`endif

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign read_data = read_data_q;
   assign err       = err_q;
   assign sd_rd_en  = sd_rd_en_q;
   assign sd_addr   = sd_addr_q;
   assign grant     = grant_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Directed bench for sd_read_arbiter: an SD model on the main instance, and a second
// instance with a short timeout driven by hand.
module tb_sd_read_arbiter;

   logic          clock = 1'b0;
   logic          reset, req0, req1, ack0, ack1, err, sd_rd_en, sd_busy, grant;
   logic [31:0]   addr0, addr1, sd_addr;
   logic [4095:0] read_data, sd_read_data;

   logic          t_reset, t_req0, t_req1, t_ack0, t_ack1, t_err, t_sd_rd_en, t_sd_busy, t_grant;
   logic [31:0]   t_addr0, t_addr1, t_sd_addr;
   logic [4095:0] t_read_data, t_sd_read_data;

   int tests_run    = 0;
   int tests_failed = 0;
   int m_state, m_cnt, cyc;

   always #5 clock = ~clock;

   sd_read_arbiter u_dut (
      .clock(clock), .reset(reset),
      .req0(req0), .addr0(addr0), .ack0(ack0),
      .req1(req1), .addr1(addr1), .ack1(ack1),
      .read_data(read_data), .err(err),
      .sd_rd_en(sd_rd_en), .sd_addr(sd_addr),
      .sd_read_data(sd_read_data), .sd_busy(sd_busy), .grant(grant)
   );

   sd_read_arbiter #(.TIMEOUT_CYCLES(64)) u_dut_to (
      .clock(clock), .reset(t_reset),
      .req0(t_req0), .addr0(t_addr0), .ack0(t_ack0),
      .req1(t_req1), .addr1(t_addr1), .ack1(t_ack1),
      .read_data(t_read_data), .err(t_err),
      .sd_rd_en(t_sd_rd_en), .sd_addr(t_sd_addr),
      .sd_read_data(t_sd_read_data), .sd_busy(t_sd_busy), .grant(t_grant)
   );

   function automatic logic [4095:0] blk(input logic [31:0] a);
      logic [4095:0] b;
      for (int i = 0; i < 128; i++) b[i*32 +: 32] = a * 32'h9E37_79B9 + 32'(i);
      return b;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ack(input bit port, input int limit, output int cycles);
      cycles = 0;
      while (((port ? ack1 : ack0) !== 1'b1) && cycles < limit) begin
         tick();
         cycles++;
      end
      check(port ? "ack1_seen" : "ack0_seen", 64'(port ? ack1 : ack0), 64'd1);
   endtask

   task automatic wait_busy(input int limit);
      int n = 0;
      while (sd_busy !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      check("busy_seen", 64'(sd_busy), 64'd1);
   endtask

   // SD controller model: busy rises 3 cycles after rd_en, falls 100 cycles later with data.
   initial begin
      sd_busy      = 1'b0;
      sd_read_data = '0;
      m_state      = 0;
      m_cnt        = 0;
      forever begin
         tick();
         if (reset) begin
            sd_busy = 1'b0;
            m_state = 0;
         end else begin
            case (m_state)
               0: if (sd_rd_en) begin m_state = 1; m_cnt = 0; end
               1: begin
                  m_cnt++;
                  if (m_cnt == 3) begin sd_busy = 1'b1; m_state = 2; m_cnt = 0; end
               end
               default: begin
                  m_cnt++;
                  if (m_cnt == 100) begin
                     sd_read_data = blk(sd_addr);
                     sd_busy      = 1'b0;
                     m_state      = 0;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
      t_reset = 1'b1; t_req0 = 1'b0; t_req1 = 1'b0; t_addr0 = '0; t_addr1 = '0;
      t_sd_busy = 1'b0; t_sd_read_data = '0;
      repeat (3) tick();
      check("rst_ack0", 64'(ack0), 64'd0);
      check("rst_ack1", 64'(ack1), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_rd_en", 64'(sd_rd_en), 64'd0);
      check("rst_sd_addr", 64'(sd_addr), 64'd0);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_rdata", 64'(read_data == '0), 64'd1);
      reset = 1'b0;
      tick();

      // Single read of port 0
      req0 = 1'b1; addr0 = 32'h0000_0010;
      tick();
      check("single_rd_en", 64'(sd_rd_en), 64'd1);
      check("single_addr", 64'(sd_addr), 64'h10);
      check("single_grant", 64'(grant), 64'd0);
      wait_busy(20);
      check("single_en_at_busy", 64'(sd_rd_en), 64'd1);
      tick();
      check("single_en_drop", 64'(sd_rd_en), 64'd0);
      wait_ack(1'b0, 300, cyc);
      check("single_err", 64'(err), 64'd0);
      check("single_addr_ack", 64'(sd_addr), 64'h10);
      check("single_rdata", 64'(read_data == blk(32'h10)), 64'd1);
      req0 = 1'b0;
      tick();
      check("single_ack_pulse", 64'(ack0), 64'd0);
      tick();
      check("single_no_reissue", 64'(sd_rd_en), 64'd0);

      // Simultaneous requests after reset, then alternation while both stay pending
      reset = 1'b1;
      tick();
      reset = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h100; addr1 = 32'h200;
      tick();
      check("both_first_grant", 64'(grant), 64'd0);
      check("both_first_addr", 64'(sd_addr), 64'h100);
      wait_ack(1'b0, 300, cyc);
      check("both_first_no_ack1", 64'(ack1), 64'd0);
      check("both_first_rdata", 64'(read_data == blk(32'h100)), 64'd1);
      req0 = 1'b0;
      tick();
      req0 = 1'b1; addr0 = 32'h300;
      tick();
      check("alt_grant1", 64'(grant), 64'd1);
      check("alt_addr1", 64'(sd_addr), 64'h200);
      tick();
      addr1 = 32'hDEAD_BEEF;
      wait_ack(1'b1, 300, cyc);
      check("addr_hold", 64'(sd_addr), 64'h200);
      check("addr_hold_rdata", 64'(read_data == blk(32'h200)), 64'd1);
      check("alt_no_ack0", 64'(ack0), 64'd0);
      req1 = 1'b0;
      tick();
      tick();
      check("alt_grant0", 64'(grant), 64'd0);
      check("alt_addr0", 64'(sd_addr), 64'h300);
      check("alt_rd_en0", 64'(sd_rd_en), 64'd1);
      wait_ack(1'b0, 300, cyc);
      check("alt_rdata0", 64'(read_data == blk(32'h300)), 64'd1);
      req0 = 1'b0;
      tick();

      // Reset during WaitDone with req0 held
      req0 = 1'b1; addr0 = 32'h40;
      tick();
      wait_busy(20);
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("mid_rst_ack0", 64'(ack0), 64'd0);
      check("mid_rst_rd_en", 64'(sd_rd_en), 64'd0);
      check("mid_rst_addr", 64'(sd_addr), 64'd0);
      check("mid_rst_rdata", 64'(read_data == '0), 64'd1);
      tick();
      check("mid_rst_ack0_b", 64'(ack0), 64'd0);
      reset = 1'b0;
      tick();
      check("after_rst_rd_en", 64'(sd_rd_en), 64'd1);
      check("after_rst_addr", 64'(sd_addr), 64'h40);
      wait_ack(1'b0, 300, cyc);
      check("after_rst_err", 64'(err), 64'd0);
      check("after_rst_rdata", 64'(read_data == blk(32'h40)), 64'd1);
      req0 = 1'b0;
      tick();

      // Back-to-back reads of the same block, then a different block
      req0 = 1'b1; addr0 = 32'h20;
      tick();
      check("b2b_first_rd_en", 64'(sd_rd_en), 64'd1);
      wait_ack(1'b0, 300, cyc);
      check("b2b_first_rdata", 64'(read_data == blk(32'h20)), 64'd1);
      req0 = 1'b0;
      tick();
      req0 = 1'b1;
      tick();
`ifdef SD_ARB_LAST_BLOCK_HIT_EN
      check("hit_ack0", 64'(ack0), 64'd1);
      check("hit_rd_en", 64'(sd_rd_en), 64'd0);
      check("hit_err", 64'(err), 64'd0);
      check("hit_rdata", 64'(read_data == blk(32'h20)), 64'd1);
      req0 = 1'b0;
      tick();
      check("hit_ack_pulse", 64'(ack0), 64'd0);
      check("hit_no_rd_en", 64'(sd_rd_en), 64'd0);
`else
      check("b2b_second_rd_en", 64'(sd_rd_en), 64'd1);
      wait_ack(1'b0, 300, cyc);
      check("b2b_second_rdata", 64'(read_data == blk(32'h20)), 64'd1);
      req0 = 1'b0;
      tick();
`endif
      req0 = 1'b1; addr0 = 32'h21;
      tick();
      check("miss_rd_en", 64'(sd_rd_en), 64'd1);
      check("miss_addr", 64'(sd_addr), 64'h21);
      wait_ack(1'b0, 300, cyc);
      check("miss_rdata", 64'(read_data == blk(32'h21)), 64'd1);
      req0 = 1'b0;
      tick();

      // Timeout instance: one good read by hand, then a read that never completes
      t_reset = 1'b0;
      t_req0 = 1'b1; t_addr0 = 32'h7;
      tick();
      check("to_good_rd_en", 64'(t_sd_rd_en), 64'd1);
      t_sd_busy = 1'b1;
      tick();
      check("to_good_en_drop", 64'(t_sd_rd_en), 64'd0);
      t_sd_busy = 1'b0; t_sd_read_data = blk(32'h7);
      tick();
      check("to_good_ack", 64'(t_ack0), 64'd1);
      check("to_good_err", 64'(t_err), 64'd0);
      check("to_good_rdata", 64'(t_read_data == blk(32'h7)), 64'd1);
      t_req0 = 1'b0; t_sd_read_data = blk(32'h99);
      tick();
      t_req0 = 1'b1; t_addr0 = 32'h80;
      tick();
      check("to_rd_en", 64'(t_sd_rd_en), 64'd1);
      cyc = 0;
      while (t_ack0 !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
      end
      check("to_latency", 64'(cyc), 64'd64);
      check("to_err", 64'(t_err), 64'd1);
      check("to_rd_en_off", 64'(t_sd_rd_en), 64'd0);
      check("to_rdata_kept", 64'(t_read_data == blk(32'h7)), 64'd1);
      t_req0 = 1'b0;
      tick();
      check("to_ack_pulse", 64'(t_ack0), 64'd0);
      check("to_err_held", 64'(t_err), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
